board_move_sequencer: RTL

//  Sequences all game-side accesses to the 8x8 board memory (3-bit cells). Takes one-cycle,
//  pre-debounced button pulses; keeps cursor, selection and turn; on power-up/game_reset,

---
 rtl/board_pkg.sv | 28 ++
 rtl/cursor_ctrl.sv | 52 +++++
 rtl/board_move_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// board_pkg: cell codes, piece ownership, sequencer states and the opening layout
// shared by the board move sequencer and its cursor controller.
package board_pkg;
    localparam logic [2:0] CELL_EMPTY = 3'd0;
    localparam logic [2:0] CELL_P1    = 3'd1;
    localparam logic [2:0] CELL_P2    = 3'd2;
    localparam logic [2:0] CELL_K1    = 3'd3;
    localparam logic [2:0] CELL_K2    = 3'd4;

    typedef enum logic [1:0] {OWN_NONE, OWN_P1, OWN_P2} owner_t;

    typedef enum logic [2:0] {
        ST_RESET, ST_CLEAR, ST_IDLE, ST_RD_SRC, ST_HELD, ST_RD_DST, ST_WR_DST, ST_WR_SRC
    } state_t;

    function automatic owner_t owner(input logic [2:0] code);
        return (code == CELL_P1 || code == CELL_K1) ? OWN_P1 :
               (code == CELL_P2 || code == CELL_K2) ? OWN_P2 : OWN_NONE;
    endfunction

    // Men sit on the dark squares ((row+col) odd) of each player's home rows.
    function automatic logic [2:0] init_cell(input int row, input int col, input int side,
                                             input int init_rows);
        return ((row + col) % 2 == 0) ? CELL_EMPTY :
               (row < init_rows)          ? CELL_P1 :
               (row >= side - init_rows)  ? CELL_P2 : CELL_EMPTY;
    endfunction
endpackage

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: cursor row/col registers; moves wrap mod board size when
// CURSOR_WRAP_EN is defined, otherwise they saturate at the board edges.
module cursor_ctrl
    import board_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             left_i,
    input  logic             right_i,
    input  logic             up_i,
    input  logic             down_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o
);
    localparam logic [IDX_W-1:0] MAX = '1;

    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0] dec_row, inc_row, dec_col, inc_col;

`ifdef CURSOR_WRAP_EN
    assign dec_row = row_q - 1'b1;
    assign inc_row = row_q + 1'b1;
    assign dec_col = col_q - 1'b1;
    assign inc_col = col_q + 1'b1;
`else
    assign dec_row = (row_q == '0)  ? row_q : row_q - 1'b1;
    assign inc_row = (row_q == MAX) ? row_q : row_q + 1'b1;
    assign dec_col = (col_q == '0)  ? col_q : col_q - 1'b1;
    assign inc_col = (col_q == MAX) ? col_q : col_q + 1'b1;
`endif

    always_comb begin
        row_d = clear_i ? '0 : up_i ? dec_row : down_i ? inc_row : row_q;
        col_d = clear_i ? '0 : left_i ? dec_col : right_i ? inc_col : col_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;
endmodule

// File: rtl/board_move_sequencer.sv
// board_move_sequencer: button-driven select/move sequencer over a req/ack board memory port.
// Define CURSOR_WRAP_EN for wrapping cursor moves (saturating otherwise).
module board_move_sequencer
    import board_pkg::*;
#(
    parameter int IDX_W     = 3,
    parameter int CELL_W    = 3,
    parameter int INIT_ROWS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    input  logic               enter,
    input  logic               game_reset,
    output logic               mem_req,
    output logic               mem_we,
    output logic [2*IDX_W-1:0] mem_addr,
    output logic [CELL_W-1:0]  mem_wdata,
    input  logic [CELL_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic [IDX_W-1:0]   cursor_row,
    output logic [IDX_W-1:0]   cursor_col,
    output logic               sel_valid,
    output logic [IDX_W-1:0]   sel_row,
    output logic [IDX_W-1:0]   sel_col,
    output logic               turn,
    output logic               busy,
    output logic               move_done,
    output logic               err
);
    localparam int AW = 2 * IDX_W;

    state_t             state_q, state_d;
    logic               req_q, req_d, pend_q, pend_d, sel_valid_q, sel_valid_d;
    logic               turn_q, turn_d, err_q, err_d, done_q, done_d;
    logic [IDX_W-1:0]   sel_row_q, sel_row_d, sel_col_q, sel_col_d;
    logic [CELL_W-1:0]  piece_q, piece_d;
    logic [AW-1:0]      clr_q, clr_d;
    logic               btn_ok, mv_enter, mv_l, mv_r, mv_u, mv_d;
    logic               acked, go_clear, at_sel;

    assign busy     = state_q inside {ST_CLEAR, ST_RD_SRC, ST_RD_DST, ST_WR_DST, ST_WR_SRC};
    assign btn_ok   = (state_q == ST_IDLE || state_q == ST_HELD) && !game_reset;
    assign mv_enter = btn_ok && enter;
    assign mv_l     = btn_ok && !enter && left;
    assign mv_r     = btn_ok && !enter && !left && right;
    assign mv_u     = btn_ok && !enter && !left && !right && up;
    assign mv_d     = btn_ok && !enter && !left && !right && !up && down;
    assign acked    = req_q && mem_ack;
    assign at_sel   = sel_row_q == cursor_row && sel_col_q == cursor_col;
    // A pending restart never abandons a request in flight: it waits for its ack.
    assign go_clear = state_q == ST_RESET || ((game_reset || pend_q) && (!req_q || mem_ack));

    cursor_ctrl #(.IDX_W(IDX_W)) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(go_clear),
        .left_i (mv_l),
        .right_i(mv_r),
        .up_i   (mv_u),
        .down_i (mv_d),
        .row_o  (cursor_row),
        .col_o  (cursor_col)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        pend_d      = pend_q | game_reset;
        sel_valid_d = sel_valid_q;
        sel_row_d   = sel_row_q;
        sel_col_d   = sel_col_q;
        turn_d      = turn_q;
        piece_d     = piece_q;
        clr_d       = clr_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        if (go_clear) begin
            state_d     = ST_CLEAR;
            req_d       = 1'b0;
            pend_d      = 1'b0;
            sel_valid_d = 1'b0;
            turn_d      = 1'b0;
            clr_d       = '0;
        end else begin
            if (busy && !req_q) req_d = 1'b1;
            if (acked) req_d = 1'b0;
            case (state_q)
                ST_IDLE: if (mv_enter) state_d = ST_RD_SRC;
                ST_HELD: if (mv_enter) begin
                    state_d     = at_sel ? ST_IDLE : ST_RD_DST;
                    sel_valid_d = !at_sel;
                end
                ST_CLEAR: if (acked) begin
                    state_d = (clr_q == '1) ? ST_IDLE : ST_CLEAR;
                    clr_d   = clr_q + 1'b1;
                end
                ST_RD_SRC: if (acked) begin
                    if (owner(mem_rdata) == (turn_q ? OWN_P2 : OWN_P1)) begin
                        state_d     = ST_HELD;
                        sel_valid_d = 1'b1;
                        sel_row_d   = cursor_row;
                        sel_col_d   = cursor_col;
                        piece_d     = mem_rdata;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_RD_DST: if (acked) begin
                    state_d = (mem_rdata == CELL_EMPTY) ? ST_WR_DST : ST_HELD;
                    err_d   = mem_rdata != CELL_EMPTY;
                end
                ST_WR_DST: if (acked) state_d = ST_WR_SRC;
                ST_WR_SRC: if (acked) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    turn_d      = !turn_q;
                    sel_valid_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            req_q       <= 1'b0;
            pend_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_row_q   <= '0;
            sel_col_q   <= '0;
            turn_q      <= 1'b0;
            piece_q     <= '0;
            clr_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pend_q      <= pend_d;
            sel_valid_q <= sel_valid_d;
            sel_row_q   <= sel_row_d;
            sel_col_q   <= sel_col_d;
            turn_q      <= turn_d;
            piece_q     <= piece_d;
            clr_q       <= clr_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = state_q inside {ST_CLEAR, ST_WR_DST, ST_WR_SRC};
    assign mem_addr  = (state_q == ST_CLEAR)  ? clr_q :
                       (state_q == ST_WR_SRC) ? {sel_row_q, sel_col_q} : {cursor_row, cursor_col};
    assign mem_wdata = (state_q == ST_CLEAR) ?
                       CELL_W'(init_cell(int'(clr_q[AW-1:IDX_W]), int'(clr_q[IDX_W-1:0]),
                                         2 ** IDX_W, INIT_ROWS)) :
                       (state_q == ST_WR_DST) ? piece_q : '0;
    assign sel_valid = sel_valid_q;
    assign sel_row   = sel_row_q;
    assign sel_col   = sel_col_q;
    assign turn      = turn_q;
    assign move_done = done_q;
    assign err       = err_q;
endmodule
